// File: rtl/vga_timing_pattern_gen_if.sv
// Pixel-side bundle of the VGA timing/pattern generator: mode controls in,
// sync, enable, coordinates, colour and frame marker out.
interface vga_timing_pattern_gen_if #(
    parameter int CW = 1,
    parameter int XW = 11,
    parameter int YW = 10
);
    logic          mode_step;
    logic          gray_force;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] red;
    logic [CW-1:0] green;
    logic [CW-1:0] blue;
    logic [1:0]    mode;
    logic          frame_start;

    modport master (
        input  mode_step, gray_force,
        output hsync, vsync, de, x, y, red, green, blue, mode, frame_start
    );

    modport slave (
        output mode_step, gray_force,
        input  hsync, vsync, de, x, y, red, green, blue, mode, frame_start
    );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing with a built-in test pattern (bars, single-channel ramps,
// checkerboard, gray override). Outputs trail the h/v counters by one pixel.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int PIX_DIV   = 1,
    parameter int CW        = 1,
    parameter int XW        = 11,
    parameter int YW        = 10
) (
    input  logic clk,
    input  logic rst,
    vga_timing_pattern_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CW-1:0] FULL = {CW{1'b1}};

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [1:0]    r_pend;
    logic [1:0]    r_mode;
    logic          r_hsync, r_vsync, r_de, r_fs;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_red, r_grn, r_blu;

    logic          w_ce, w_h_last, w_v_last, w_origin, w_de, w_hs_act, w_vs_act;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [2:0]    w_bar;
    logic [1:0]    w_mode_nx;
    logic [CW-1:0] w_red, w_grn, w_blu;

    // Pixel enable fires on the first clk after reset, so pixel (0,0) comes out immediately.
    always_ff @(posedge clk) begin
        if (rst || r_div == DW'(PIX_DIV - 1)) r_div <= '0;
        else                                  r_div <= r_div + 1'b1;
    end
    assign w_ce = (r_div == '0);

    assign w_h_last = (r_h == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v == VW'(V_TOTAL - 1));
    assign w_origin = (r_h == '0) && (r_v == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_ce) begin
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                r_pend <= 2'd0;
        else if (bus.mode_step) r_pend <= r_pend + 2'd1;
    end

    assign w_de      = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
    assign w_hs_act  = (r_h >= HW'(H_ACTIVE + H_FP)) && (r_h < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs_act  = (r_v >= VW'(V_ACTIVE + V_FP)) && (r_v < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign w_x       = w_de ? XW'(r_h) : '0;
    assign w_y       = w_de ? YW'(r_v) : '0;
    assign w_bar     = 3'((32'(w_x) * 32'd8) / 32'(H_ACTIVE));
    // The new frame's mode already applies to the colour of pixel (0,0).
    assign w_mode_nx = w_origin ? r_pend : r_mode;

    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        if (w_de) begin
            if (bus.gray_force) begin
                if (w_bar != 3'd0) begin
                    w_red = FULL;
                    w_grn = FULL;
                    w_blu = FULL;
                end
            end else begin
                case (w_mode_nx)
                    2'd0: begin
                        w_red = {CW{w_bar[2]}};
                        w_grn = {CW{w_bar[1]}};
                        w_blu = {CW{w_bar[0]}};
                    end
                    2'd1:    if (w_bar != 3'd0) w_red = FULL;
                    2'd2:    if (w_bar != 3'd0) w_grn = FULL;
                    default: if (w_x[5] ^ w_y[5]) begin
                        w_red = FULL;
                        w_grn = FULL;
                        w_blu = FULL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_de    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_red   <= '0;
            r_grn   <= '0;
            r_blu   <= '0;
            r_mode  <= 2'd0;
        end else if (w_ce) begin
            r_hsync <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_de    <= w_de;
            r_x     <= w_x;
            r_y     <= w_y;
            r_red   <= w_red;
            r_grn   <= w_grn;
            r_blu   <= w_blu;
            r_mode  <= w_mode_nx;
        end
    end

    // One clk wide even when a pixel spans several clks.
    always_ff @(posedge clk) begin
        if (rst) r_fs <= 1'b0;
        else     r_fs <= w_ce && w_origin;
    end

    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.red         = r_red;
    assign bus.green       = r_grn;
    assign bus.blue        = r_blu;
    assign bus.mode        = r_mode;
    assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: two instances (1 and 3 clk per pixel, opposite
// sync polarities) on a small raster, compared every clk against an arithmetic model.
module tb_vga_timing_pattern_gen;
    localparam int HA = 64, HFP = 4, HS = 8, HB = 4;
    localparam int VA = 40, VFP = 2, VS = 3, VB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FR = HT * VT;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_pattern_gen_if #(.CW(CW), .XW(11), .YW(10)) bus0 ();
    vga_timing_pattern_gen_if #(.CW(CW), .XW(11), .YW(10)) bus1 ();

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(1), .CW(CW), .XW(11), .YW(10)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(3), .CW(CW), .XW(11), .YW(10)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int failures = 0;

    // Model state: k = clk edges since reset release (-1 while in reset).
    int k = -1;
    int pend[2];
    int mdisp[2];
    bit gl[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [5:0] colour(input int x, input int y, input bit de,
                                          input bit gray, input int mode);
        logic [1:0] r, g, b;
        int bar;
        r = 2'b00; g = 2'b00; b = 2'b00;
        bar = (x * 8) / HA;
        if (de) begin
            if (gray) begin
                if (bar != 0) begin r = 2'b11; g = 2'b11; b = 2'b11; end
            end else if (mode == 0) begin
                r = ((bar >> 2) & 1) != 0 ? 2'b11 : 2'b00;
                g = ((bar >> 1) & 1) != 0 ? 2'b11 : 2'b00;
                b = (bar & 1) != 0 ? 2'b11 : 2'b00;
            end else if (mode == 1) begin
                if (bar != 0) r = 2'b11;
            end else if (mode == 2) begin
                if (bar != 0) g = 2'b11;
            end else if ((((x >> 5) ^ (y >> 5)) & 1) != 0) begin
                r = 2'b11; g = 2'b11; b = 2'b11;
            end
        end
        return {r, g, b};
    endfunction

    task automatic check_dut(input int i, input logic hs, input logic vs, input logic de,
                             input logic [10:0] x, input logic [9:0] y,
                             input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                             input logic [1:0] mode, input logic fs);
        int d, n, h, v, ex, ey;
        bit pol, ede, ehs, evs, efs;
        logic [5:0] ergb;
        int emode;
        d   = (i == 0) ? 1 : 3;
        pol = (i == 0);
        if (k < 0) begin
            ehs = !pol; evs = !pol; ede = 0; ex = 0; ey = 0; ergb = '0; emode = 0; efs = 0;
        end else begin
            n   = k / d;
            h   = n % HT;
            v   = (n / HT) % VT;
            ede = (h < HA) && (v < VA);
            ex  = ede ? h : 0;
            ey  = ede ? v : 0;
            ehs = (h >= HA + HFP && h < HA + HFP + HS) ? pol : !pol;
            evs = (v >= VA + VFP && v < VA + VFP + VS) ? pol : !pol;
            efs = (k % d == 0) && (n % FR == 0);
            emode = mdisp[i];
            ergb  = colour(ex, ey, ede, gl[i], mdisp[i]);
        end
        chk($sformatf("dut%0d_sync", i), 32'({hs, vs}), 32'({ehs, evs}));
        chk($sformatf("dut%0d_de_xy", i), 32'({de, x, y}), 32'({ede, 11'(ex), 10'(ey)}));
        chk($sformatf("dut%0d_rgb", i), 32'({r, g, b}), 32'(ergb));
        chk($sformatf("dut%0d_mode", i), 32'(mode), 32'(emode));
        chk($sformatf("dut%0d_frame_start", i), 32'(fs), 32'(efs));
    endtask

    task automatic step(input bit r, input bit ms, input bit gf);
        int d;
        rst = r;
        bus0.mode_step = ms;  bus1.mode_step = ms;
        bus0.gray_force = gf; bus1.gray_force = gf;
        @(posedge clk);
        if (r) begin
            k = -1;
            for (int i = 0; i < 2; i++) begin pend[i] = 0; mdisp[i] = 0; gl[i] = 0; end
        end else begin
            k++;
            for (int i = 0; i < 2; i++) begin
                d = (i == 0) ? 1 : 3;
                if (k % d == 0) begin
                    if ((k / d) % FR == 0) mdisp[i] = pend[i];
                    gl[i] = gf;
                end
                if (ms) pend[i] = (pend[i] + 1) % 4;
            end
        end
        #1;
        check_dut(0, bus0.hsync, bus0.vsync, bus0.de, bus0.x, bus0.y,
                  bus0.red, bus0.green, bus0.blue, bus0.mode, bus0.frame_start);
        check_dut(1, bus1.hsync, bus1.vsync, bus1.de, bus1.x, bus1.y,
                  bus1.red, bus1.green, bus1.blue, bus1.mode, bus1.frame_start);
    endtask

    task automatic run_random(input int n, input int step_odds, input int gray_odds);
        bit gf;
        gf = 0;
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(gray_odds - 1, 0) == 0) gf = !gf;
            step(0, $urandom_range(step_odds - 1, 0) == 0, gf);
        end
    endtask

    initial begin
        bus0.mode_step = 0; bus1.mode_step = 0;
        bus0.gray_force = 0; bus1.gray_force = 0;

        // Reset, with mode_step pulses that must be ignored.
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);

        // Two frames of random mode steps and gray runs.
        run_random(2 * FR, 300, 200);

        // Two mode_step pulses mid-frame (line 20) without gray.
        for (int t = 0; t < FR && (k % FR) != 20 * HT; t++) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        for (int t = 0; t < FR && ((k + 1) % FR) != 0; t++) step(0, 0, 0);
        // Pulse lands on the frame-load clk of the 1-clk instance.
        step(0, 1, 0);
        for (int t = 0; t < FR && (k % FR) != 25 * HT + 40; t++) step(0, 0, 0);

        // Mid-frame reset for three clks, then a clean restart.
        step(1, 0, 0);
        step(1, 1, 1);
        step(1, 0, 0);
        run_random(FR + 200, 250, 300);

        // Long enough to cover full frames of the 3-clk-per-pixel instance.
        run_random(12000, 400, 150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_pattern_gen.md
VGA_TIMING_PATTERN_GEN -- requirements
Module: vga_timing_pattern_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 SHALL provide parameters H_FP, H_SYNC, H_BP, defaults 56, 120, 64, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL provide parameter V_ACTIVE, default 600, meaning visible lines per frame.
REQ-004 SHALL provide parameters V_FP, V_SYNC, V_BP, defaults 37, 6, 23, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL provide parameters HSYNC_POL and VSYNC_POL, default 1, meaning sync active level (1 = active-high).
REQ-006 SHALL provide parameter PIX_DIV, default 1, range 1..16, meaning clk cycles per pixel.
REQ-007 SHALL provide parameter CW, default 1, meaning bits per colour channel.
REQ-008 SHALL provide parameters XW and YW, defaults 11 and 10, meaning coordinate widths.
REQ-009 Reset rst, synchronous, active-high; clock clk.
REQ-010 Ports, in order:
- clk in 1: system clock.
- rst in 1: synchronous active-high reset.
- mode_step in 1: one-clk pulse that advances the pattern mode.
- gray_force in 1: level input that forces grayscale output.
- hsync out 1: horizontal sync.
- vsync out 1: vertical sync.
- de out 1: display enable, high during the active area.
- x out XW: active pixel column.
- y out YW: active line.
- red out CW, green out CW, blue out CW: colour channels.
- mode out 2: currently displayed mode.
- frame_start out 1: one-clk pulse marking pixel (0,0).

Function
REQ-011 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-012 The pixel enable ce SHALL assert for one clk in every PIX_DIV clks, and SHALL be constantly high when PIX_DIV=1.
REQ-013 The horizontal counter h SHALL count 0..H_TOTAL-1 on ce and wrap to 0.
REQ-014 The vertical counter v SHALL increment on ce only when h wraps, and SHALL itself wrap from V_TOTAL-1 to 0.
REQ-015 Line order SHALL be active, front porch, sync, back porch.
REQ-016 Horizontal sync SHALL be active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vertical sync SHALL use the same rule on v with the V parameters.
REQ-017 The hsync/vsync pins SHALL drive the POL level when sync is active and the inverse level otherwise.
REQ-018 de SHALL be high when h<H_ACTIVE and v<V_ACTIVE.
REQ-019 While de=1, x=h and y=v; while de=0, x=0 and y=0.
REQ-020 All outputs SHALL be registered and updated on ce only; they reflect counter state with a latency of exactly 1 ce, and all outputs are mutually aligned.
REQ-021 red/green/blue SHALL be all zero whenever de=0.
REQ-022 Bar index SHALL be bar = (x*8)/H_ACTIVE, range 0..7.
REQ-023 Full level SHALL be all CW bits set.
REQ-024 Mode 0, colour bars: red = bar[2], green = bar[1], blue = bar[0], each bit replicated to CW bits.
REQ-025 Mode 1: red = full when bar != 0, otherwise 0; green = blue = 0.
REQ-026 Mode 2: same as mode 1, on green.
REQ-027 Mode 3: checkerboard; all channels = full when x[5]^y[5] = 1, otherwise 0.
REQ-028 gray_force=1 SHALL override the mode and drive all three channels = full when bar != 0, otherwise 0, effective on the next ce.
REQ-029 Each mode_step pulse SHALL increment a pending mode modulo 4; multiple pulses within one frame accumulate, and 3 wraps to 0.
REQ-030 mode SHALL load the pending mode only at the counter position h=0, v=0; the displayed mode never changes mid-frame.
REQ-031 A mode_step pulse arriving in the same clk as the frame load takes effect at the following frame.
REQ-032 frame_start SHALL be high for exactly one clk, aligned with the output of pixel (0,0), including when PIX_DIV>1.

Reset
REQ-033 While rst=1, h, v, the ce divider, pending mode and mode SHALL clear to 0, and mode_step SHALL be ignored.
REQ-034 After the first clk edge with rst=1: de=0, x=0, y=0, RGB=0, frame_start=0, and hsync/vsync at their inactive levels.
REQ-035 Assertion of rst mid-frame SHALL abort the frame.
REQ-036 After rst deasserts, the first output ce SHALL present pixel (0,0) with frame_start=1.

Verification
REQ-037 Defaults, two full frames: hsync period = 1040 clk with a high width of 120; vsync high width = 6*1040 clk; frame period = 692640 clk; de high for 800 clk on each of 600 lines.
REQ-038 Mode 0, line 0: RGB = 000 for x=0..99, 001 for x=100..199, and so on to 111 for x=700..799; RGB = 0 for x >= 800.
REQ-039 Pulse mode_step twice at v=300: mode stays 0 until the next frame_start, then mode=2; green = 0 for x<100 and 1 for x >= 100.
REQ-040 PIX_DIV=2, HSYNC_POL=0: hsync period = 2080 clk with a low width of 240 clk; x advances every 2 clk; frame_start stays one clk wide.
REQ-041 Assert rst at h=400, v=200 for 3 clk: outputs go to their reset values; after release, frame_start and pixel (0,0) follow on the next ce and mode=0.
